// File: rtl/fetch_stage_ctrl.sv
// IF stage: owns the PC, drives a multi-cycle instruction memory and the IF/ID register.
// Buffers one response that lands during a stall; responses to flushed requests are discarded.
module fetch_stage_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        Stall_i,
  input  logic        Flush_i,
  input  logic [31:0] target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        valid_o,
  output logic        fetch_busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redir_q, redir_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_vld_q, ifid_vld_d;
  logic        ld_mem, ld_buf;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    redir_d     = redir_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    ld_mem      = 1'b0;
    ld_buf      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Flush_i) pc_d = target_i;
        if (start_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack_i) begin
          if (Flush_i) begin
            pc_d = target_i;
          end else if (Stall_i) begin
            buf_pc_d    = pc_q;
            buf_instr_d = imem_data_i;
            pc_d        = pc_q + 32'd4;
            state_d     = S_HOLD;
          end else begin
            ld_mem = 1'b1;
            pc_d   = pc_q + 32'd4;
          end
        end else if (Flush_i) begin
          // Address must stay put until the ack, so park the redirect.
          redir_d = target_i;
          state_d = S_DROP;
        end
      end
      S_HOLD: begin
        if (Flush_i) begin
          pc_d    = target_i;
          state_d = S_FETCH;
        end else if (!Stall_i) begin
          ld_buf  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_DROP: begin
        if (Flush_i) redir_d = target_i;
        if (imem_ack_i) begin
          pc_d    = Flush_i ? target_i : redir_q;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_vld_d   = ifid_vld_q;
    if (Flush_i) begin
      ifid_pc_d    = 32'd0;
      ifid_instr_d = NOP_INSTR;
      ifid_vld_d   = 1'b0;
    end else if (!Stall_i) begin
      if (ld_mem) begin
        ifid_pc_d    = pc_q;
        ifid_instr_d = imem_data_i;
        ifid_vld_d   = 1'b1;
      end else if (ld_buf) begin
        ifid_pc_d    = buf_pc_q;
        ifid_instr_d = buf_instr_q;
        ifid_vld_d   = 1'b1;
      end else begin
        ifid_pc_d    = 32'd0;
        ifid_instr_d = NOP_INSTR;
        ifid_vld_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      redir_q      <= RESET_PC;
      buf_pc_q     <= 32'd0;
      buf_instr_q  <= NOP_INSTR;
      ifid_pc_q    <= 32'd0;
      ifid_instr_q <= NOP_INSTR;
      ifid_vld_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redir_q      <= redir_d;
      buf_pc_q     <= buf_pc_d;
      buf_instr_q  <= buf_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_vld_q   <= ifid_vld_d;
    end
  end

  assign imem_req_o   = (state_q == S_FETCH) || (state_q == S_DROP);
  assign fetch_busy_o = imem_req_o;
  assign imem_addr_o  = pc_q;
  assign pc_o         = ifid_pc_q;
  assign instr_o      = ifid_instr_q;
  assign valid_o      = ifid_vld_q;

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Directed bench for fetch_stage_ctrl: per-cycle vector table plus a latency-2 memory run.
module tb_fetch_stage_ctrl;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0, start_i = 1'b0, Stall_i = 1'b0, Flush_i = 1'b0;
  logic [31:0] target_i = 32'd0;
  logic        imem_req_o, imem_ack_i = 1'b0, valid_o, fetch_busy_o;
  logic [31:0] imem_addr_o, imem_data_i = 32'd0, pc_o, instr_o;

  int checks = 0;
  int failures = 0;

  fetch_stage_ctrl dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .Stall_i(Stall_i), .Flush_i(Flush_i),
    .target_i(target_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i), .pc_o(pc_o), .instr_o(instr_o),
    .valid_o(valid_o), .fetch_busy_o(fetch_busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, start, stall, flush, ack;
    logic [31:0] target, data;
    logic        e_req, e_vld, e_busy;
    logic [31:0] e_addr, e_pc, e_instr;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hC0DE0000;
  endfunction

  function automatic vec_t mk(input logic rst, start, stall, flush, input logic [31:0] target,
                              input logic ack, input logic [31:0] data,
                              input logic e_req, input logic [31:0] e_addr, e_pc, e_instr,
                              input logic e_vld, e_busy);
    vec_t v;
    v.rst = rst; v.start = start; v.stall = stall; v.flush = flush; v.target = target;
    v.ack = ack; v.data = data; v.e_req = e_req; v.e_addr = e_addr; v.e_pc = e_pc;
    v.e_instr = e_instr; v.e_vld = e_vld; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=%h expected=%h", name, row, act, exp);
    end
  endtask

  initial begin
    int got, cyc, wait_cnt;
    logic [31:0] exp_pc;

    // rst start stall flush target ack data | req addr pc instr vld busy
    vecs.push_back(mk(1,0,0,0,32'h0,  0,32'h0,       0,32'h0,  32'h0,  NOP,        0,0)); // 0 reset
    vecs.push_back(mk(0,0,0,0,32'h0,  0,32'h0,       0,32'h0,  32'h0,  NOP,        0,0)); // 1 idle
    vecs.push_back(mk(0,1,0,0,32'h0,  0,32'h0,       1,32'h0,  32'h0,  NOP,        0,1)); // 2 start
    vecs.push_back(mk(0,0,0,0,32'h0,  1,word(32'h0), 1,32'h4,  32'h0,  word(32'h0),1,1)); // 3
    vecs.push_back(mk(0,0,0,0,32'h0,  1,word(32'h4), 1,32'h8,  32'h4,  word(32'h4),1,1)); // 4
    vecs.push_back(mk(0,0,1,0,32'h0,  1,word(32'h8), 0,32'hC,  32'h4,  word(32'h4),1,0)); // 5 ack under stall
    vecs.push_back(mk(0,0,1,0,32'h0,  0,32'h0,       0,32'hC,  32'h4,  word(32'h4),1,0)); // 6
    vecs.push_back(mk(0,0,1,0,32'h0,  0,32'h0,       0,32'hC,  32'h4,  word(32'h4),1,0)); // 7
    vecs.push_back(mk(0,0,0,0,32'h0,  0,32'h0,       1,32'hC,  32'h8,  word(32'h8),1,1)); // 8 buffer drains
    vecs.push_back(mk(0,0,0,0,32'h0,  1,word(32'hC), 1,32'h10, 32'hC,  word(32'hC),1,1)); // 9
    vecs.push_back(mk(0,0,0,0,32'h0,  0,32'h0,       1,32'h10, 32'h0,  NOP,        0,1)); // 10 bubble
    vecs.push_back(mk(0,0,0,1,32'h100,0,32'h0,       1,32'h10, 32'h0,  NOP,        0,1)); // 11 flush -> DROP
    vecs.push_back(mk(0,0,0,0,32'h0,  0,32'h0,       1,32'h10, 32'h0,  NOP,        0,1)); // 12
    vecs.push_back(mk(0,0,0,0,32'h0,  1,word(32'h10),1,32'h100,32'h0,  NOP,        0,1)); // 13 stale ack dropped
    vecs.push_back(mk(0,0,0,0,32'h0,  1,word(32'h100),1,32'h104,32'h100,word(32'h100),1,1)); // 14
    vecs.push_back(mk(0,0,1,1,32'h200,1,word(32'h104),1,32'h200,32'h0, NOP,        0,1)); // 15 flush beats stall
    vecs.push_back(mk(0,0,0,0,32'h0,  1,word(32'h200),1,32'h204,32'h200,word(32'h200),1,1)); // 16
    vecs.push_back(mk(0,0,0,1,32'h300,0,32'h0,       1,32'h204,32'h0,  NOP,        0,1)); // 17 DROP
    vecs.push_back(mk(0,0,0,1,32'hFFFFFFFC,0,32'h0,  1,32'h204,32'h0,  NOP,        0,1)); // 18 newer target
    vecs.push_back(mk(0,0,0,0,32'h0,  1,word(32'h204),1,32'hFFFFFFFC,32'h0,NOP,    0,1)); // 19
    vecs.push_back(mk(0,0,0,0,32'h0,  1,word(32'hFFFFFFFC),1,32'h0,32'hFFFFFFFC,word(32'hFFFFFFFC),1,1)); // 20 wrap
    vecs.push_back(mk(1,0,0,0,32'h0,  0,32'h0,       0,32'h0,  32'h0,  NOP,        0,0)); // 21 reset mid-request
    vecs.push_back(mk(0,0,0,0,32'h0,  1,32'hDEADBEEF,0,32'h0,  32'h0,  NOP,        0,0)); // 22 stray ack
    vecs.push_back(mk(0,0,0,1,32'h40, 0,32'h0,       0,32'h40, 32'h0,  NOP,        0,0)); // 23 flush in IDLE
    vecs.push_back(mk(0,1,0,0,32'h0,  0,32'h0,       1,32'h40, 32'h0,  NOP,        0,1)); // 24
    vecs.push_back(mk(0,0,1,0,32'h0,  1,word(32'h40),0,32'h44, 32'h0,  NOP,        0,0)); // 25 HOLD
    vecs.push_back(mk(0,0,0,1,32'h80, 0,32'h0,       1,32'h80, 32'h0,  NOP,        0,1)); // 26 flush empties buffer
    vecs.push_back(mk(0,0,0,0,32'h0,  1,word(32'h80),1,32'h84, 32'h80, word(32'h80),1,1)); // 27
    vecs.push_back(mk(0,0,1,0,32'h0,  0,32'h0,       1,32'h84, 32'h80, word(32'h80),1,1)); // 28 stall holds

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_i = vecs[i].rst; start_i = vecs[i].start; Stall_i = vecs[i].stall;
      Flush_i = vecs[i].flush; target_i = vecs[i].target;
      imem_ack_i = vecs[i].ack; imem_data_i = vecs[i].data;
      @(posedge clk);
      #1;
      chk("req",   i, {31'd0, imem_req_o},   {31'd0, vecs[i].e_req});
      chk("addr",  i, imem_addr_o,           vecs[i].e_addr);
      chk("pc",    i, pc_o,                  vecs[i].e_pc);
      chk("instr", i, instr_o,               vecs[i].e_instr);
      chk("valid", i, {31'd0, valid_o},      {31'd0, vecs[i].e_vld});
      chk("busy",  i, {31'd0, fetch_busy_o}, {31'd0, vecs[i].e_busy});
    end

    // Memory answering on the second cycle of each request; expect an in-order stream from 0.
    @(negedge clk);
    rst_i = 1; start_i = 0; Stall_i = 0; Flush_i = 0; imem_ack_i = 0;
    @(negedge clk);
    rst_i = 0; start_i = 1;
    @(negedge clk);
    start_i = 0;
    got = 0; cyc = 0; wait_cnt = 0; exp_pc = 32'h0;
    while (got < 8 && cyc < 200) begin
      if (imem_req_o && wait_cnt == 1) begin
        imem_ack_i = 1; imem_data_i = word(imem_addr_o); wait_cnt = 0;
      end else begin
        imem_ack_i = 0;
        if (imem_req_o) wait_cnt++;
      end
      @(posedge clk);
      #1;
      if (valid_o) begin
        chk("stream_pc",    got, pc_o,    exp_pc);
        chk("stream_instr", got, instr_o, word(exp_pc));
        exp_pc += 32'd4;
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    imem_ack_i = 0;
    checks++;
    if (got != 8) begin
      failures++;
      $display("FAIL stream_timeout got=%0d expected=8", got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
